// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 encodings, FSM state encoding and the decoded op-flag layout.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic is_div;
        logic signed_a;
        logic signed_b;
        logic want_high;
        logic want_rem;
    } op_flags_t;

endpackage

// File: rtl/muldiv_op_decode.sv
// Combinational funct3 decoder producing the operation flags latched at accept.
module muldiv_op_decode
    import muldiv_pkg::*;
(
    input  logic [2:0] funct3,
    output op_flags_t  flags_c
);

    always_comb begin
        flags_c = '0;
        case (funct3)
            F3_MUL:    ;
            F3_MULH:   begin flags_c.signed_a = 1'b1; flags_c.signed_b = 1'b1; flags_c.want_high = 1'b1; end
            F3_MULHSU: begin flags_c.signed_a = 1'b1; flags_c.want_high = 1'b1; end
            F3_MULHU:  flags_c.want_high = 1'b1;
            F3_DIV:    begin flags_c.is_div = 1'b1; flags_c.signed_a = 1'b1; flags_c.signed_b = 1'b1; end
            F3_DIVU:   flags_c.is_div = 1'b1;
            F3_REM:    begin flags_c.is_div = 1'b1; flags_c.signed_a = 1'b1; flags_c.signed_b = 1'b1; flags_c.want_rem = 1'b1; end
            F3_REMU:   begin flags_c.is_div = 1'b1; flags_c.want_rem = 1'b1; end
            default:   flags_c = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and
// restoring divider, one bit per cycle, with a 1-cycle path for div special cases.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned W2 = 2 * XLEN;
    localparam int unsigned RW = XLEN + 1;
    localparam int unsigned TW = XLEN + 2;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [W2-1:0]   acc, acc_next;
    logic [RW-1:0]   rem, rem_next;
    logic [XLEN-1:0] mag_b, mag_b_next;
    op_flags_t       flags, flags_next, dec_flags;
    logic            sign_a, sign_a_next, sign_b, sign_b_next;
    logic [XLEN-1:0] result_next;
    logic            out_valid_next;

    muldiv_op_decode u_decode (
        .funct3  (funct3),
        .flags_c (dec_flags)
    );

    // Operand conditioning at accept: magnitudes and special-case detection
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a_in, mag_b_in, special_res;
    assign a_neg       = dec_flags.signed_a & src_a[XLEN-1];
    assign b_neg       = dec_flags.signed_b & src_b[XLEN-1];
    assign mag_a_in    = a_neg ? XLEN'(-src_a) : src_a;
    assign mag_b_in    = b_neg ? XLEN'(-src_b) : src_b;
    assign div_zero    = dec_flags.is_div && (src_b == '0);
    assign div_ovf     = dec_flags.is_div && dec_flags.signed_a && (src_a == XMIN) && (src_b == '1);
    assign special_res = div_zero ? (dec_flags.want_rem ? src_a : '1)
                                  : (dec_flags.want_rem ? '0 : XMIN);

    // One iteration of either datapath; acc low half is multiplier or dividend/quotient
    logic [RW-1:0] mul_sum;
    logic [TW-1:0] rem_sh, trial;
    assign mul_sum = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign rem_sh  = {rem, acc[XLEN-1]};
    assign trial   = rem_sh - {2'b00, mag_b};

    // Sign correction and result selection
    logic            neg;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo, remv, fix_res;
    assign neg     = (flags.is_div && flags.want_rem) ? (flags.signed_a & sign_a)
                   : ((flags.signed_a & sign_a) ^ (flags.signed_b & sign_b));
    assign prod    = neg ? W2'(-acc) : acc;
    assign quo     = neg ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    assign remv    = neg ? XLEN'(-rem[XLEN-1:0]) : rem[XLEN-1:0];
    assign fix_res = flags.is_div ? (flags.want_rem ? remv : quo)
                                  : (flags.want_high ? prod[W2-1:XLEN] : prod[XLEN-1:0]);

    // Next-state and datapath update
    always_comb begin
        state_next     = state;
        count_next     = count;
        acc_next       = acc;
        rem_next       = rem;
        mag_b_next     = mag_b;
        flags_next     = flags;
        sign_a_next    = sign_a;
        sign_b_next    = sign_b;
        result_next    = result;
        out_valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready && !flush) begin
                    flags_next  = dec_flags;
                    sign_a_next = src_a[XLEN-1];
                    sign_b_next = src_b[XLEN-1];
                    mag_b_next  = mag_b_in;
                    acc_next    = {{XLEN{1'b0}}, mag_a_in};
                    rem_next    = '0;
                    count_next  = CNT_W'(XLEN);
                    if (div_zero || div_ovf) begin
                        result_next = special_res;
                        state_next  = DONE;
                    end else begin
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - CNT_W'(1);
                    if (flags.is_div) begin
                        rem_next = trial[TW-1] ? RW'(rem_sh) : RW'(trial);
                        acc_next = {acc[W2-1:XLEN], acc[XLEN-2:0], ~trial[TW-1]};
                    end else begin
                        acc_next = {mul_sum, acc[XLEN-1:1]};
                    end
                    if (count == CNT_W'(1)) state_next = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    result_next    = fix_res;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                // A fast-path entry spends one cycle here with out_valid still low
                if (flush || (out_valid && out_ready)) begin
                    state_next = IDLE;
                end else begin
                    out_valid_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            rem       <= '0;
            mag_b     <= '0;
            flags     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            count     <= count_next;
            acc       <= acc_next;
            rem       <= rem_next;
            mag_b     <= mag_b_next;
            flags     <= flags_next;
            sign_a    <= sign_a_next;
            sign_b    <= sign_b_next;
            result    <= result_next;
            out_valid <= out_valid_next;
            busy      <= (state_next != IDLE);
            in_ready  <= (state_next == IDLE);
        end
    end

endmodule
